// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - latches button press pulses and arbitrates them round-robin into a valid/ready event stream
//
// Ports:
//   CLK         system clock, all logic on posedge
//   RESET       synchronous active-high reset
//   PULSE       single-cycle press pulses, one bit per button
//   EVT_VALID   event offered to the consumer
//   EVT_ID      index of the offered button
//   EVT_READY   consumer accepts the event
//   PENDING     latched, not-yet-granted requests
//   DROP_COUNT  saturating count of cycles with at least one dropped press
//   BUSY        high whenever the FSM is not idle

module button_event_arbiter #(
    parameter int NUM_BTN        = 5,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_BTN-1:0]         PULSE,
    output logic                       EVT_VALID,
    output logic [$clog2(NUM_BTN)-1:0] EVT_ID,
    input  logic                       EVT_READY,
    output logic [NUM_BTN-1:0]         PENDING,
    output logic [CNT_W-1:0]           DROP_COUNT,
    output logic                       BUSY
);

    localparam int ID_W = $clog2(NUM_BTN);
    localparam int HC_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_BTN-1:0]  pending;
    logic [NUM_BTN-1:0]  grant_clr;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     evt_id_q;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     hi_idx;
    logic [ID_W-1:0]     lo_idx;
    logic                hi_found;
    logic                lo_found;
    logic                grant;
    logic [HC_W-1:0]     hold_cnt;
    logic [HC_W-1:0]     hold_next;
    logic [CNT_W-1:0]    drop_count;
    logic                drop_any;

    // Round-robin pick: the lowest pending index above last_grant wins;
    // if none exists the search wraps, so the lowest pending index overall wins.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pending[i] && !hi_found && (i > int'(last_grant))) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
            if (pending[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (lo_found) begin
                    grant      = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (EVT_READY) begin
                    if (HOLDOFF_CYCLES > 0) begin
                        state_next = HOLDOFF;
                        hold_next  = HC_W'(HOLDOFF_CYCLES);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                hold_next = hold_cnt - 1'b1;
                if (hold_cnt == HC_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_clr = '0;
        if (grant) begin
            grant_clr[winner] = 1'b1;
        end
    end

    // A pulse on the bit being granted this cycle is a fresh request, not a drop.
    assign drop_any = |(PULSE & pending & ~grant_clr);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending    <= '0;
            evt_id_q   <= '0;
            last_grant <= ID_W'(NUM_BTN - 1);
            hold_cnt   <= '0;
            drop_count <= '0;
        end else begin
            pending  <= (pending & ~grant_clr) | PULSE;
            hold_cnt <= hold_next;
            if (grant) begin
                evt_id_q   <= winner;
                last_grant <= winner;
            end
            if (drop_any && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign EVT_VALID  = (state == OFFER);
    assign BUSY       = (state != IDLE);
    assign EVT_ID     = evt_id_q;
    assign PENDING    = pending;
    assign DROP_COUNT = drop_count;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter

module tb_button_event_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] PULSE;
    logic       EVT_VALID;
    logic [2:0] EVT_ID;
    logic       EVT_READY;
    logic [4:0] PENDING;
    logic [1:0] DROP_COUNT;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;
    int lows;

    button_event_arbiter #(
        .NUM_BTN(5),
        .HOLDOFF_CYCLES(4),
        .CNT_W(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PULSE(PULSE),
        .EVT_VALID(EVT_VALID),
        .EVT_ID(EVT_ID),
        .EVT_READY(EVT_READY),
        .PENDING(PENDING),
        .DROP_COUNT(DROP_COUNT),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until EVT_VALID is seen, counting the low cycles on the way.
    // Any PULSE set by the caller lasts exactly one cycle.
    task automatic wait_valid(output int n_low);
        logic found;
        found = 1'b0;
        n_low = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            PULSE = '0;
            if (EVT_VALID === 1'b1) found = 1'b1;
            else n_low++;
        end
        chk("wait_valid_found", {31'd0, found}, 32'd1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        PULSE = '0;
        step();
        step();
        RESET = 1'b0;
    endtask

    initial begin
        EVT_READY = 1'b1;
        do_reset();
        chk("rst_valid", EVT_VALID, 0);
        chk("rst_pending", PENDING, 0);
        chk("rst_drop", DROP_COUNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_id", EVT_ID, 0);

        // Single press latency
        PULSE = 5'b00100;
        step();
        PULSE = '0;
        chk("t1_pending", PENDING, 5'b00100);
        chk("t1_valid_early", EVT_VALID, 0);
        step();
        chk("t1_valid", EVT_VALID, 1);
        chk("t1_id", EVT_ID, 2);
        chk("t1_pending_clr", PENDING, 0);
        chk("t1_busy", BUSY, 1);
        step();
        chk("t1_valid_one_cycle", EVT_VALID, 0);
        repeat (4) step();
        chk("t1_idle", BUSY, 0);

        // Simultaneous presses, round-robin from reset
        do_reset();
        PULSE = 5'b10011;
        step();
        PULSE = '0;
        chk("t2_pending", PENDING, 5'b10011);
        wait_valid(lows);
        chk("t2_lows0", lows, 0);
        chk("t2_id0", EVT_ID, 0);
        wait_valid(lows);
        chk("t2_lows1", lows, 5);
        chk("t2_id1", EVT_ID, 1);
        wait_valid(lows);
        chk("t2_lows2", lows, 5);
        chk("t2_id2", EVT_ID, 4);
        chk("t2_drop", DROP_COUNT, 0);

        // Backpressure with a re-press and a drop
        do_reset();
        EVT_READY = 1'b0;
        PULSE = 5'b01000;
        step();
        PULSE = '0;
        step();
        chk("t3_valid", EVT_VALID, 1);
        chk("t3_id", EVT_ID, 3);
        for (int c = 0; c < 10; c++) begin
            PULSE = (c == 2 || c == 5) ? 5'b01000 : 5'b00000;
            step();
            chk("t3_hold_valid", EVT_VALID, 1);
            chk("t3_hold_id", EVT_ID, 3);
        end
        PULSE = '0;
        chk("t3_pending", PENDING, 5'b01000);
        chk("t3_drop", DROP_COUNT, 1);
        EVT_READY = 1'b1;
        wait_valid(lows);
        chk("t3_lows", lows, 5);
        chk("t3_id2", EVT_ID, 3);

        // Fairness: last grant 3 -> 4 before 0; last grant 4 -> 0 before 4
        PULSE = 5'b10001;
        wait_valid(lows);
        chk("t4_id_a", EVT_ID, 4);
        wait_valid(lows);
        chk("t4_id_b", EVT_ID, 0);
        PULSE = 5'b10000;
        wait_valid(lows);
        chk("t4_id_c", EVT_ID, 4);
        PULSE = 5'b10001;
        wait_valid(lows);
        chk("t4_id_d", EVT_ID, 0);
        wait_valid(lows);
        chk("t4_id_e", EVT_ID, 4);
        chk("t4_drop", DROP_COUNT, 1);

        // Drop counter saturation (2-bit counter)
        do_reset();
        EVT_READY = 1'b0;
        PULSE = 5'b00011;
        step();
        PULSE = '0;
        step();
        chk("t5_offer_id", EVT_ID, 0);
        chk("t5_pending", PENDING, 5'b00010);
        PULSE = 5'b00010;
        step();
        chk("t5_drop1", DROP_COUNT, 1);
        step();
        chk("t5_drop2", DROP_COUNT, 2);
        step();
        chk("t5_drop3", DROP_COUNT, 3);
        step();
        chk("t5_drop4", DROP_COUNT, 3);
        step();
        chk("t5_drop5", DROP_COUNT, 3);
        PULSE = '0;

        // Same-cycle clear and set on the granted bit
        do_reset();
        EVT_READY = 1'b1;
        PULSE = 5'b00010;
        step();
        PULSE = 5'b00010;
        step();
        PULSE = '0;
        chk("t6_valid", EVT_VALID, 1);
        chk("t6_id", EVT_ID, 1);
        chk("t6_pending", PENDING, 5'b00010);
        chk("t6_drop", DROP_COUNT, 0);
        wait_valid(lows);
        chk("t6_lows", lows, 5);
        chk("t6_id2", EVT_ID, 1);

        // Reset while offering with requests pending
        EVT_READY = 1'b0;
        PULSE = 5'b01001;
        step();
        chk("t7_pending_pre", PENDING, 5'b01001);
        RESET = 1'b1;
        PULSE = 5'b00100;
        step();
        RESET = 1'b0;
        PULSE = '0;
        chk("t7_valid", EVT_VALID, 0);
        chk("t7_pending", PENDING, 0);
        chk("t7_drop", DROP_COUNT, 0);
        chk("t7_busy", BUSY, 0);
        chk("t7_id", EVT_ID, 0);
        PULSE = 5'b01001;
        step();
        PULSE = '0;
        step();
        chk("t7_valid2", EVT_VALID, 1);
        chk("t7_id2", EVT_ID, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
